// File: rtl/buffer_read_controller_if.sv
// Handshake bundle between the buffer read controller and its input buffer, scratchpad and PE.
// The controller takes the master side; the buffer/scratchpad/PE environment takes the slave side.
interface buffer_read_controller_if #(
    parameter int AW = 4
);
    logic          go;
    logic          valid;
    logic          done;
    logic          stall_in;
    logic          ren;
    logic          sp_wen;
    logic [AW-1:0] sp_addr;
    logic          sp_bank;
    logic          start;
    logic          stall;
    logic          layer_done;

    modport master (
        input  go, valid, done, stall_in,
        output ren, sp_wen, sp_addr, sp_bank, start, stall, layer_done
    );

    modport slave (
        output go, valid, done, stall_in,
        input  ren, sp_wen, sp_addr, sp_bank, start, stall, layer_done
    );
endinterface

// File: rtl/buffer_read_controller.sv
// Loads one window of LEN words per PE run into the scratchpad, pulses start, waits for done, NWIN times per layer.
// Define PREFETCH_EN for a double-banked scratchpad that prefetches the next window while the PE computes.
module buffer_read_controller #(
    parameter int LEN  = 16,
    parameter int AW   = 4,
    parameter int NWIN = 4
) (
    input  logic clk,
    input  logic rst,
    buffer_read_controller_if.master bus
);

    localparam int WW = (NWIN > 1) ? $clog2(NWIN) : 1;
    localparam logic [AW-1:0] LAST_WORD = AW'(LEN - 1);
    localparam logic [WW-1:0] LAST_WIN  = WW'(NWIN - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_START   = 3'd2,
        S_COMPUTE = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] wcnt;
    logic [AW-1:0] wcnt_next;
    logic [WW-1:0] win;
    logic [WW-1:0] win_next;

    logic          ren;
    logic          sp_wen;
    logic [AW-1:0] sp_addr;
    logic          sp_bank;
    logic          start;
    logic          stall;
    logic          layer_done;

`ifdef PREFETCH_EN
    // cur is the bank the PE reads; pf_full marks the other bank as holding a complete next window
    logic cur;
    logic cur_next;
    logic pf_full;
    logic pf_full_next;
    logic pf_active;
    logic pf_last;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            wcnt  <= '0;
            win   <= '0;
`ifdef PREFETCH_EN
            cur     <= 1'b0;
            pf_full <= 1'b0;
`endif
        end else begin
            state <= state_next;
            wcnt  <= wcnt_next;
            win   <= win_next;
`ifdef PREFETCH_EN
            cur     <= cur_next;
            pf_full <= pf_full_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
        wcnt_next  = wcnt;
        win_next   = win;
        ren        = 1'b0;
        sp_wen     = 1'b0;
        sp_addr    = '0;
        sp_bank    = 1'b0;
        start      = 1'b0;
        stall      = 1'b0;
        layer_done = 1'b0;
`ifdef PREFETCH_EN
        cur_next     = cur;
        pf_full_next = pf_full;
        pf_active    = 1'b0;
        pf_last      = 1'b0;
`endif

        case (state)
            S_IDLE: begin
                if (bus.go) begin
                    state_next = S_LOAD;
                    wcnt_next  = '0;
                    win_next   = '0;
`ifdef PREFETCH_EN
                    cur_next     = 1'b0;
                    pf_full_next = 1'b0;
`endif
                end
            end

            // wcnt only moves on accepted words, so a gappy valid never skips or repeats an address
            S_LOAD: begin
                ren     = bus.valid;
                sp_wen  = bus.valid;
                sp_addr = wcnt;
                stall   = !bus.valid;
`ifdef PREFETCH_EN
                sp_bank = cur;
`endif
                if (bus.valid) begin
                    if (wcnt == LAST_WORD) begin
                        wcnt_next  = '0;
                        state_next = S_START;
                    end else begin
                        wcnt_next = wcnt + 1'b1;
                    end
                end
            end

            S_START: begin
                start = !bus.stall_in;
`ifdef PREFETCH_EN
                sp_bank = cur;
`endif
                if (!bus.stall_in) begin
                    state_next = S_COMPUTE;
                end
            end

            S_COMPUTE: begin
`ifdef PREFETCH_EN
                sp_bank   = cur;
                pf_active = (win != LAST_WIN) && !pf_full;
                if (pf_active) begin
                    ren     = bus.valid;
                    sp_wen  = bus.valid;
                    sp_addr = wcnt;
                    if (bus.valid) begin
                        sp_bank      = !cur;
                        pf_last      = (wcnt == LAST_WORD);
                        wcnt_next    = pf_last ? '0 : wcnt + 1'b1;
                        pf_full_next = pf_last;
                    end
                end
                // A partial prefetch resumes in LOAD at the retained wcnt, now writing the new cur bank
                if (bus.done) begin
                    if (win == LAST_WIN) begin
                        state_next = S_FINISH;
                    end else begin
                        win_next     = win + 1'b1;
                        cur_next     = !cur;
                        pf_full_next = 1'b0;
                        state_next   = (pf_full || pf_last) ? S_START : S_LOAD;
                    end
                end
`else
                if (bus.done) begin
                    if (win == LAST_WIN) begin
                        state_next = S_FINISH;
                    end else begin
                        win_next   = win + 1'b1;
                        state_next = S_LOAD;
                    end
                end
`endif
            end

            S_FINISH: begin
                layer_done = 1'b1;
`ifdef PREFETCH_EN
                sp_bank = cur;
`endif
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign bus.ren        = ren;
    assign bus.sp_wen     = sp_wen;
    assign bus.sp_addr    = sp_addr;
    assign bus.sp_bank    = sp_bank;
    assign bus.start      = start;
    assign bus.stall      = stall;
    assign bus.layer_done = layer_done;

endmodule

// File: doc/buffer_read_controller.md
# buffer_read_controller

Read-side controller for the convolution input path: drains ifmap/filter words from the input buffer into the PE scratchpad one window at a time, issues a compute start pulse per window, and waits for the PE's `done` before loading the next window. It is the upstream counterpart of the psum write controller. The two controllers share the same `valid`/`ren` buffer handshake style and the same `done` from the PE. It raises `layer_done` after `NWIN` windows.

## Interface
- `LEN`, 16: words per window loaded into the scratchpad (2..2^AW).
- `AW`, 4: scratchpad word-address width.
- `NWIN`, 4: windows per layer (≥1).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low (asserted at 0).
- `go`  in  1  start a layer; sampled only in IDLE.
- `valid`  in  1  input buffer has a word on its output.
- `done`  in  1  PE finished the current window (1-cycle pulse).
- `stall_in`  in  1  write controller stalled; blocks new `start`.
- `ren`  out  1  pop input buffer this cycle.
- `sp_wen`  out  1  write scratchpad this cycle.
- `sp_addr`  out  AW  scratchpad word address.
- `sp_bank`  out  1  scratchpad bank select (0 unless `PREFETCH_EN`).
- `start`  out  1  PE start pulse.
- `stall`  out  1  controller waiting on buffer data while loading.
- `layer_done`  out  1  1-cycle pulse after last window completes.

## Operation
- States: IDLE, LOAD, START, COMPUTE, FINISH. Word counter `wcnt` (AW bits), window counter `win` (clog2(NWIN) bits, min 1).
- IDLE: all outputs 0.
  - `go`=1 → LOAD, with `wcnt`=0 and `win`=0.
- LOAD:
  - Outputs: `ren`=`sp_wen`=`valid`; `sp_addr`=`wcnt`; `stall`=!`valid`.
  - On `valid`: `wcnt`++.
  - On `valid` && `wcnt`==LEN-1: `wcnt`←0, → START.
- START: `start`=!`stall_in`.
  - Stays in START while `stall_in`=1.
  - → COMPUTE on the cycle `start`=1.
- COMPUTE: waits for `done`.
  - On `done`: if `win`==NWIN-1 → FINISH; else `win`++ → LOAD.
- FINISH: `layer_done`=1 for one cycle → IDLE.
- Boundaries:
  - `go` outside IDLE: ignored.
  - `done` outside COMPUTE: ignored.
  - `valid` outside LOAD: no pop (`ren`=0), except the prefetch case.
  - `valid` toggling mid-LOAD: the counter advances only on accepted words, so no holes or duplicate addresses.
  - Undefined state encoding: → IDLE, outputs 0.

## Timing
- Reset (async, `rst`=0): state IDLE, `wcnt`=`win`=0, `sp_bank`=0.
  - Outputs `ren`, `sp_wen`, `sp_addr`, `start`, `stall`, `layer_done` all 0.
  - Reset mid-operation aborts the layer immediately; no partial `layer_done`.
- Outputs are combinational from state, `valid` and `stall_in`; state and counters are registered.
- `ren` and `sp_wen` are asserted in the same cycle as `valid`; the buffer pops and the scratchpad writes on the same edge.
- Window load latency: LEN cycles minimum (`valid` held high) from LOAD entry to START.
- `start`: exactly one cycle high per window.
- Minimum layer latency without prefetch: 1 (IDLE→LOAD) + NWIN·(LEN + 1 + Tpe) + 1 cycles, where Tpe is cycles from `start` to `done`.

## Configuration
- `PREFETCH_EN` undefined:
  - `sp_bank` tied 0.
  - The scratchpad is single-banked; LOAD and COMPUTE never overlap.
- `PREFETCH_EN` defined: double-buffered scratchpad.
  - In COMPUTE with `win`<NWIN-1: `ren`=`sp_wen`=`valid` until LEN words are prefetched, then `ren`=0. During prefetch, `sp_bank`=!cur and `sp_addr`=`wcnt`.
  - Without a write, `sp_bank` shows cur, the bank being computed.
  - On `done`:
    - cur toggles and `win`++.
    - If the prefetch is complete: → START with `wcnt`=0.
    - Otherwise: → LOAD, continuing at the retained `wcnt` into the new cur bank.
  - `stall` is never asserted in COMPUTE.

## Test plan
- LEN=4, NWIN=2, `valid` held 1, `done` returned 3 cycles after `start`:
  - `sp_addr` sequence 0,1,2,3 per window.
  - 2 `start` pulses and 1 `layer_done`; total 1+2·(4+1+3)+1=18 cycles from `go`.
- `valid` pattern 1,0,0,1,1,0,1 in LOAD: writes to addresses 0,1,2,3 only on `valid` cycles; `stall`=1 exactly on the 3 gap cycles.
- `stall_in`=1 for 5 cycles on entering START: `start` stays 0 for those 5 cycles, then a single pulse after `stall_in` falls.
- `rst`=0 asserted mid-LOAD at `wcnt`=2: outputs 0 asynchronously. A subsequent `go` restarts at address 0 and `win`=0.
- Spurious `done` in LOAD, and `go` in COMPUTE: no state change and no extra `start`.
- `PREFETCH_EN`, LEN=4, NWIN=3, `valid`=1, Tpe=6:
  - Window 1 is written to bank 1 during window 0's COMPUTE.
  - After `done`, START follows directly with no LOAD; bank alternates 0,1,0.
